// File: rtl/config_chain_pkg.sv
// config_chain_pkg: shared FSM states and sizing helpers for the configuration chain loader
package config_chain_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: parallel-load word shift register with a per-word bit counter
module ccff_word_serializer #(
  parameter int WORD_W = 8,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [CNT_W-1:0]  len,
  output logic              head,
  output logic              last_bit
);
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  word_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg    <= '0;
      word_cnt <= '0;
    end else if (load) begin
      shreg    <= data;
      word_cnt <= len;
    end else if (shift) begin
      shreg    <= shreg >> 1;
      word_cnt <= word_cnt - CNT_W'(1);
    end
  assign head     = shreg[0];
  assign last_bit = word_cnt == CNT_W'(1);
endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: serializes handshaked bitstream words LSB-first onto the ccff chain
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W = 8,
  localparam int CNT_W = cnt_width(CHAIN_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left
);
  state_t           state, state_n;
  logic [CNT_W-1:0] bits_n;
  logic             head, last_bit, load;
  assign busy      = state != IDLE;
  assign prog_en   = state == SHIFT;
  assign done      = state == DONE;
  assign cfg_ready = (state == FETCH) && !abort;
  assign load      = cfg_valid && cfg_ready;
  assign ccff_head = prog_en && head;
  // the final word is clamped so bits beyond the chain length are never shifted out
  ccff_word_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_ser (
    .clk,
    .reset,
    .load,
    .shift(prog_en && !abort),
    .data(cfg_data),
    .len(CNT_W'(min_u(WORD_W, 32'(bits_left)))),
    .head,
    .last_bit
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      bits_left <= '0;
    end else begin
      state     <= state_n;
      bits_left <= bits_n;
    end
  always_comb begin
    state_n = state;
    bits_n  = bits_left;
    case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        bits_n  = CNT_W'(CHAIN_LEN);
      end
      FETCH: if (load) state_n = SHIFT;
      SHIFT: begin
        bits_n = bits_left - CNT_W'(1);
        if (last_bit) state_n = bits_left == CNT_W'(1) ? DONE : FETCH;
      end
      default: begin
        state_n = IDLE;
        bits_n  = '0;
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      bits_n  = '0;
    end
  end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: directed self-checking bench for config_chain_loader
module tb_config_chain_loader;
  logic       clk = 0, reset = 1;
  logic       start = 0, abort = 0, cfg_valid = 0;
  logic [7:0] cfg_data = 0;
  logic       cfg_ready, ccff_head, prog_en, busy, done;
  logic [4:0] bits_left;
  logic       start10 = 0, abort10 = 0, valid10 = 0;
  logic [7:0] data10 = 0;
  logic       ready10, head10, prog10, busy10, done10;
  logic [3:0] left10;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
    .clk, .reset, .start, .abort, .cfg_data, .cfg_valid, .cfg_ready,
    .ccff_head, .prog_en, .busy, .done, .bits_left
  );
  config_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
    .clk, .reset, .start(start10), .abort(abort10), .cfg_data(data10), .cfg_valid(valid10),
    .cfg_ready(ready10), .ccff_head(head10), .prog_en(prog10), .busy(busy10), .done(done10),
    .bits_left(left10)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pass16(input int stall, input bit poke);
    logic [15:0] bits;
    int pcnt, dcnt, dcyc, c;
    bits = 0; pcnt = 0; dcnt = 0; dcyc = -1; c = 0;
    start = 1; cfg_valid = 1; cfg_data = 8'hA5;
    while (c < 22 + stall) begin
      cyc;
      c++;
      start = poke && c == 5;
      if (c == 1) begin
        chk("fetch_ready", cfg_ready, 1);
        chk("fetch_bits_left", bits_left, 16);
      end
      if (prog_en) begin
        if (pcnt < 16) bits[pcnt] = ccff_head;
        pcnt++;
      end
      if (done) begin
        dcnt++;
        dcyc = c;
      end
      if (pcnt > 0) cfg_data = 8'h3C;
      if (stall > 0 && cfg_ready && pcnt == 8) begin
        cfg_valid = 0;
        for (int s = 0; s < stall; s++) begin
          cyc;
          c++;
          chk("stall_prog_en", prog_en, 0);
          chk("stall_bits_left", bits_left, 8);
        end
        cfg_valid = 1;
      end
    end
    cfg_valid = 0;
    start = 0;
    chk("pass_bits", bits, 16'h3CA5);
    chk("pass_prog_cycles", pcnt, 16);
    chk("pass_done_count", dcnt, 1);
    chk("pass_done_cycle", dcyc, 19 + stall);
    chk("pass_idle", busy, 0);
  endtask
  initial begin
    logic [9:0] bits10;
    int p, d, dc;
    #12;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_ccff_head", ccff_head, 0);
    chk("rst_prog_en", prog_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bits_left", bits_left, 0);
    @(negedge clk);
    reset = 0;
    cyc;
    pass16(0, 0);
    pass16(5, 0);
    pass16(0, 1);
    start = 1; abort = 1;
    cyc;
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_bits", bits_left, 0);
    cyc;
    chk("start_abort_busy2", busy, 0);
    chk("start_abort_done", done, 0);
    start = 1; cfg_valid = 1; cfg_data = 8'hA5;
    cyc;
    start = 0;
    for (int i = 0; i < 30 && bits_left != 5; i++) cyc;
    chk("abort_reach_bits", bits_left, 5);
    chk("abort_reach_prog", prog_en, 1);
    abort = 1;
    cyc;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_prog_en", prog_en, 0);
    chk("abort_bits_left", bits_left, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cfg_ready, 0);
    cyc;
    chk("abort_done_next", done, 0);
    start = 1;
    cyc;
    start = 0;
    chk("fetch_abort_pre", cfg_ready, 1);
    abort = 1;
    #1;
    chk("fetch_abort_gate", cfg_ready, 0);
    cyc;
    abort = 0;
    chk("fetch_abort_busy", busy, 0);
    chk("fetch_abort_bits", bits_left, 0);
    cfg_valid = 0;
    cyc;
    pass16(0, 0);
    start = 1; cfg_valid = 1; cfg_data = 8'hA5;
    cyc;
    start = 0;
    cyc;
    cyc;
    chk("async_pre_prog", prog_en, 1);
    #2 reset = 1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_prog_en", prog_en, 0);
    chk("async_ccff_head", ccff_head, 0);
    chk("async_bits_left", bits_left, 0);
    chk("async_cfg_ready", cfg_ready, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    reset = 0;
    cfg_valid = 0;
    cyc;
    pass16(0, 0);
    bits10 = 0; p = 0; d = 0; dc = -1;
    start10 = 1; valid10 = 1; data10 = 8'hFF;
    for (int c = 1; c <= 16; c++) begin
      cyc;
      start10 = 0;
      if (prog10) begin
        if (p < 10) bits10[p] = head10;
        p++;
      end
      if (done10) begin
        d++;
        dc = c;
      end
      if (p > 0) data10 = 8'h02;
    end
    valid10 = 0;
    chk("partial_bits", bits10, 10'h2FF);
    chk("partial_prog_cycles", p, 10);
    chk("partial_done_count", d, 1);
    chk("partial_done_cycle", dc, 13);
    chk("partial_idle", busy10, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
